key_sched_sequencer: RTL and testbench
======================================

// Module: key_sched_sequencer
// PURPOSE
//  Iterative AES-128 key-schedule controller. Replaces the fully unrolled 10-stage expansion.
//  Shares one 4-byte SubWord unit (4 SubBytes instances, 1-cycle registered lookup on clk) across all 10 rounds.
//  Builds the 1408-bit schedule one 32-bit word per cycle, with a start/busy/done handshake.
//  Sits between the AES top-level FSM and AddRoundKey; the FSM pulses start, then waits for done.
// PARAMETERS
//  NROUNDS      10   number of round keys generated after the cipher key (fixed for AES-128)
//  SUB_LATENCY  1    SubBytes lookup latency in cycles; sets the SUB-state dwell time
// PORTS
//  clk           in   1     system clock; all state updates on the rising edge
//  Reset         in   1     synchronous, active-high reset
//  start         in   1     request expansion; sampled only in IDLE or DONE
//  cipher_key    in   128   key; captured on the start-accept edge, ignored at all other times
//  busy          out  1     high while expansion is in progress
//  done          out  1     high in DONE; held until the next accepted start or Reset
//  round_idx     out  4     round currently being built (1..10); 0 when not busy
//  key_schedule  out  1408  [1407:1280] = cipher key, [1279:1152] = round 1 ... [127:0] = round 10
// BEHAVIOUR
//  Reset (any state, including mid-expansion):
//   - state=IDLE; busy=0; done=0; round_idx=0; key_schedule=0; rcon=8'h01.
//  FSM: IDLE -> SUB -> W0 -> W1 -> W2 -> W3 -> (SUB | DONE); DONE -> SUB on start.
//   - IDLE/DONE + start=1: key_schedule <= {cipher_key, 1280'b0}; rcon <= 8'h01; round_idx <= 1; go to SUB.
//   - SUB (SUB_LATENCY cycles): drive SubBytes with RotWord(prev w3) = {b1,b2,b3,b0}.
//   - W0: w0 = prev_w0 ^ SubWord ^ {rcon, 24'h0}.
//   - W1..W3: wi = prev_wi ^ w(i-1).
//   - Each Wn writes its word into the round_idx slot of key_schedule.
//   - W3, round_idx < 10: round_idx++; rcon <= xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00); go to SUB.
//   - W3, round_idx == 10: go to DONE; round_idx <= 0.
//  Latency: start accepted on edge E -> done=1 and busy=0 visible after edge E+50 (10 rounds x 5 cycles).
//  busy=1 exactly in SUB/W0..W3; busy and done are never both high.
//  start while busy: ignored, no effect on the sequence.
//  start held high continuously: re-accepted in DONE -> done falls for a full 50-cycle run, then rises again.
//  Words not yet generated read 0; already-written round-key slots are stable once written.
//  rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
//  No arithmetic besides XOR and xtime; all widths exact, no truncation.
// CONFIGURATION
//  Macro KEYSCHED_RK_PORT_EN:
//   - defined: adds ports rk_sel in 4 and rk_out out 128.
//   - rk_out <= slot rk_sel of key_schedule, registered, 1-cycle latency (0 = cipher key, 10 = round 10).
//   - rk_sel > 10 -> rk_out = 0; rk_out = 0 on Reset.
//   - Valid round keys only once done=1; rk_sel reads during busy return the partially built slot.
//  Undefined: the ports do not exist; no select mux or extra register is synthesized.
// TESTING
//  Reset, start=0 for 5 cycles -> busy=0, done=0, round_idx=0, key_schedule=0.
//  start=1 for 1 cycle, cipher_key=2b7e151628aed2a6abf7158809cf4f3c; wait for done:
//   - done rises exactly 50 cycles after the accept edge.
//   - round1 = a0fafe1788542cb123a339392a6c7605.
//   - round10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
//  cipher_key=0, start -> round1 = 62636363626363636263636362636363, round10 = b4ef5bcb3e92e21123e951cf6f8f188e.
//  Mid-run disturbance:
//   - start pulse and cipher_key change at cycle 20 of a run -> ignored; result matches the first key.
//   - Reset at cycle 23 -> all outputs 0 the next cycle; a fresh start completes correctly.
//  Back-to-back runs with start held high -> done low for 50 cycles between runs; rcon restarts at 01 each run.
//  KEYSCHED_RK_PORT_EN: after done:
//   - rk_sel=1 -> rk_out = a0fafe17... on the next cycle.
//   - rk_sel=11 -> rk_out = 0.

Source files
------------

// File: rtl/key_sched_sequencer.sv
// rtl/key_sched_sequencer.sv - iterative AES-128 key expansion, one 32-bit word per cycle
// Optional round-key read port enabled by macro KEYSCHED_RK_PORT_EN.
module key_sched_sequencer #(
    parameter int NROUNDS     = 10,
    parameter int SUB_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         start,
    input  logic [127:0]                 cipher_key,
    output logic                         busy,
    output logic                         done,
    output logic [3:0]                   round_idx,
    output logic [128*(NROUNDS+1)-1:0]   key_schedule
`ifdef KEYSCHED_RK_PORT_EN
    ,
    input  logic [3:0]                   rk_sel,
    output logic [127:0]                 rk_out
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SUB  = 3'd1;
    localparam logic [2:0] S_W0   = 3'd2;
    localparam logic [2:0] S_W1   = 3'd3;
    localparam logic [2:0] S_W2   = 3'd4;
    localparam logic [2:0] S_W3   = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [2:0]   state;
    logic [7:0]   sub_cnt;
    logic [7:0]   rcon;
    logic [127:0] work;
    logic [31:0]  sub_in;
    logic [31:0]  sub_word;
    logic [31:0]  new_word;
    logic [1:0]   word_sel;
    logic [10:0]  wr_pos;

    // work holds the round key under construction; words are replaced in place,
    // so after W(i-1) the freshly built w(i-1) sits directly above prev_wi.
    always_comb begin
        sub_in   = {work[23:0], work[31:24]};
        word_sel = 2'(state - S_W0);
        wr_pos   = 11'(32 * (4 * (NROUNDS - int'(round_idx)) + 3 - int'(word_sel)));
        new_word = '0;
        case (state)
            S_W0:    new_word = work[127:96] ^ sub_word ^ {rcon, 24'h0};
            S_W1:    new_word = work[95:64] ^ work[127:96];
            S_W2:    new_word = work[63:32] ^ work[95:64];
            S_W3:    new_word = work[31:0]  ^ work[63:32];
            default: new_word = '0;
        endcase
    end

    always_comb begin
        busy = (state >= S_SUB) && (state <= S_W3);
        done = (state == S_DONE);
    end

    // Shared SubWord unit: four byte lookups registered on clk.
    always_ff @(posedge clk) begin
        if (Reset) begin
            sub_word <= '0;
        end else begin
            sub_word <= {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]],
                         SBOX[sub_in[15:8]],  SBOX[sub_in[7:0]]};
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state        <= S_IDLE;
            sub_cnt      <= '0;
            rcon         <= 8'h01;
            round_idx    <= '0;
            work         <= '0;
            key_schedule <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        key_schedule <= {cipher_key, {(128*NROUNDS){1'b0}}};
                        work         <= cipher_key;
                        rcon         <= 8'h01;
                        round_idx    <= 4'd1;
                        sub_cnt      <= '0;
                        state        <= S_SUB;
                    end
                end
                S_SUB: begin
                    if (sub_cnt == 8'(SUB_LATENCY - 1)) begin
                        sub_cnt <= '0;
                        state   <= S_W0;
                    end else begin
                        sub_cnt <= sub_cnt + 8'd1;
                    end
                end
                S_W0, S_W1, S_W2, S_W3: begin
                    key_schedule[wr_pos +: 32] <= new_word;
                    case (word_sel)
                        2'd0:    work[127:96] <= new_word;
                        2'd1:    work[95:64]  <= new_word;
                        2'd2:    work[63:32]  <= new_word;
                        default: work[31:0]   <= new_word;
                    endcase
                    if (state != S_W3) begin
                        state <= state + 3'd1;
                    end else if (round_idx == 4'(NROUNDS)) begin
                        round_idx <= '0;
                        state     <= S_DONE;
                    end else begin
                        round_idx <= round_idx + 4'd1;
                        rcon      <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                        state     <= S_SUB;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef KEYSCHED_RK_PORT_EN
    logic [10:0] rk_pos;

    always_comb begin
        rk_pos = (int'(rk_sel) <= NROUNDS) ? 11'(128 * (NROUNDS - int'(rk_sel))) : 11'd0;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            rk_out <= '0;
        end else if (int'(rk_sel) <= NROUNDS) begin
            rk_out <= key_schedule[rk_pos +: 128];
        end else begin
            rk_out <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_key_sched_sequencer.sv
// tb/tb_key_sched_sequencer.sv - self-checking bench for key_sched_sequencer
module tb_key_sched_sequencer;

    localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] A_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_R1    = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_R10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam int           RUN_CYC = 50;

    logic           clk = 1'b0;
    logic           Reset = 1'b1;
    logic           start = 1'b0;
    logic [127:0]   cipher_key = '0;
    logic           busy;
    logic           done;
    logic [3:0]     round_idx;
    logic [1407:0]  key_schedule;
`ifdef KEYSCHED_RK_PORT_EN
    logic [3:0]     rk_sel = '0;
    logic [127:0]   rk_out;
`endif

    key_sched_sequencer dut (
        .clk          (clk),
        .Reset        (Reset),
        .start        (start),
        .cipher_key   (cipher_key),
        .busy         (busy),
        .done         (done),
        .round_idx    (round_idx),
        .key_schedule (key_schedule)
`ifdef KEYSCHED_RK_PORT_EN
        ,
        .rk_sel       (rk_sel),
        .rk_out       (rk_out)
`endif
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] sb [256];
    logic       chk_on = 1'b0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_ks(input string name, input logic [1407:0] got, input logic [1407:0] exp);
        int j;
        total++;
        if (got !== exp) begin
            bad++;
            j = 0;
            while (j < 43 && got[1407-32*j -: 32] === exp[1407-32*j -: 32]) j++;
            $display("FAIL %s word=%0d got=%h exp=%h", name, j, got[1407-32*j -: 32], exp[1407-32*j -: 32]);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = '0;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] expand(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1407:0] r;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
        return r;
    endfunction

    // Model: 0 idle, 1 running (m_t cycles since accept), 2 done.
    int            m_mode = 0;
    int            m_t = 0;
    logic [1407:0] m_full = '0;

    always @(posedge clk) begin
        if (Reset) begin
            m_mode <= 0;
            m_t    <= 0;
            m_full <= '0;
        end else if (m_mode != 1 && start) begin
            m_mode <= 1;
            m_t    <= 0;
            m_full <= expand(cipher_key);
        end else if (m_mode == 1) begin
            m_t <= m_t + 1;
            if (m_t == RUN_CYC - 1) m_mode <= 2;
        end
    end

    always @(negedge clk) begin
        logic [1407:0] e;
        int            k;
        if (chk_on) begin
            if (m_mode == 1) begin
                k = 4 + (m_t / 5) * 4 + ((m_t % 5 > 1) ? (m_t % 5 - 1) : 0);
                e = m_full & ~({1408{1'b1}} >> (32 * k));
                check("busy", busy, 1);
                check("done", done, 0);
                check("round_idx", round_idx, 128'(m_t / 5 + 1));
            end else begin
                e = (m_mode == 2) ? m_full : '0;
                check("busy", busy, 0);
                check("done", done, (m_mode == 2) ? 1 : 0);
                check("round_idx", round_idx, 0);
            end
            check_ks("key_schedule", key_schedule, e);
        end
    end

    task automatic do_start(input logic [127:0] key);
        @(posedge clk);
        #2 cipher_key = key;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        check("done_reached", done, 1);
    endtask

    initial begin
        int n;
        int lo;
        build_sbox();
        check("sbox_00", sb[0], 8'h63);
        check("sbox_53", sb[8'h53], 8'hed);
        m_full = expand(KEY_A);
        check("model_a_r1", m_full[1279:1152], A_R1);
        check("model_a_r10", m_full[127:0], A_R10);
        m_full = '0;

        @(posedge clk);
        #2 chk_on = 1'b1;
        repeat (5) @(posedge clk);
        #2 Reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_round", round_idx, 0);
        check("rst_ks_zero", (key_schedule == '0) ? 1 : 0, 1);

        do_start(KEY_A);
        wait_done(n);
        check("latency", n, RUN_CYC);
        check("a_r1", key_schedule[1279:1152], A_R1);
        check("a_r10", key_schedule[127:0], A_R10);
        check("a_key", key_schedule[1407:1280], KEY_A);

        do_start(128'h0);
        wait_done(n);
        check("z_r1", key_schedule[1279:1152], Z_R1);
        check("z_r10", key_schedule[127:0], Z_R10);

        // start pulse and key change while busy must be ignored
        do_start(KEY_A);
        repeat (19) @(posedge clk);
        #2 cipher_key = KEY_B;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        wait_done(n);
        check("ign_r1", key_schedule[1279:1152], A_R1);
        check("ign_r10", key_schedule[127:0], A_R10);

        // reset in the middle of a run
        do_start(KEY_A);
        repeat (22) @(posedge clk);
        #2 Reset = 1'b1;
        @(posedge clk);
        #2 Reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_round", round_idx, 0);
        check("midrst_ks", (key_schedule == '0) ? 1 : 0, 1);
        do_start(128'h0);
        wait_done(n);
        check("post_rst_latency", n, RUN_CYC);
        check("post_rst_r10", key_schedule[127:0], Z_R10);

        // start held high: re-accept from DONE
        @(posedge clk);
        #2 cipher_key = KEY_A;
        start = 1'b1;
        wait_done(n);
        n = 0;
        while (done && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        lo = 1;
        while (!done && lo < 200) begin
            @(posedge clk);
            #1 if (!done) lo++;
        end
        check("b2b_low", lo, RUN_CYC);
        start = 1'b0;
        check("b2b_r1", key_schedule[1279:1152], A_R1);
        check("b2b_r10", key_schedule[127:0], A_R10);

`ifdef KEYSCHED_RK_PORT_EN
        @(posedge clk);
        #2 rk_sel = 4'd1;
        @(posedge clk);
        #1 check("rk_1", rk_out, A_R1);
        #1 rk_sel = 4'd11;
        @(posedge clk);
        #1 check("rk_11", rk_out, 0);
        #1 rk_sel = 4'd0;
        @(posedge clk);
        #1 check("rk_0", rk_out, KEY_A);
`endif
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
